// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state, PC type and reset-vector default for the fetch PC generator
package pc_pkg;

    localparam int PC_XLEN = 32;

    typedef logic [PC_XLEN-1:0] pc_t;

    localparam pc_t PC_RESET_VEC = '0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; overflow overwrites the oldest entry
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_val_i,
    input  logic            pop_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW:0]     cnt_q, cnt_d;

    // pointer wraps naturally; count saturates so a full stack keeps overwriting
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = (cnt_q == (PW+1)'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
        end else if (pop_i && cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage, written at the current pointer on push
    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[ptr_q] <= push_val_i;
    end

    assign top_o   = mem_q[ptr_q - 1'b1];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered fetch PC with stall hold, trap/redirect priority and buffered redirect; optional RAS via PC_RAS_EN
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN        = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC),
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            hold_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            redirect_pending_o,
    output logic            ras_empty_o
);

    localparam logic [XLEN-1:0] INC  = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] MASK = ~(XLEN'(INSTR_BYTES - 1));

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pend_q, pend_d;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty, ras_push, ras_pop, stall;

    assign stall = stall_i | hold_i;

    // next-state selection: start gate, then trap > redirect > return > stall > increment
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!start_i) begin
            state_d = IDLE;
            pc_d    = RESET_VEC;
            pend_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (trap_i) begin
                        pc_d = trap_vec_i & MASK;
                    end else if (redirect_i && !stall) begin
                        pc_d     = redirect_pc_i & MASK;
                        ras_push = call_i;
                    end else if (redirect_i) begin
                        pend_d  = redirect_pc_i & MASK;
                        state_d = PEND;
                    end else if (ret_i && !ras_empty && !stall) begin
                        pc_d    = ras_top & MASK;
                        ras_pop = 1'b1;
                    end else if (!stall) begin
                        pc_d = pc_q + INC;
                    end
                end
                PEND: begin
                    if (trap_i) begin
                        pc_d    = trap_vec_i & MASK;
                        pend_d  = '0;
                        state_d = RUN;
                    end else if (stall) begin
                        pend_d = redirect_i ? (redirect_pc_i & MASK) : pend_q;
                    end else begin
                        pc_d     = redirect_i ? (redirect_pc_i & MASK) : pend_q;
                        ras_push = redirect_i & call_i;
                        pend_d   = '0;
                        state_d  = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state, PC and pending-target registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN (XLEN),
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (ras_push),
        .push_val_i(pc_q + INC),
        .pop_i     (ras_pop),
        .top_o     (ras_top),
        .empty_o   (ras_empty)
    );
`else
    logic unused_ras;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ras_push ^ ras_pop ^ (RAS_DEPTH == 0);
`endif

    assign pc_o               = pc_q;
    assign pc_valid_o         = (state_q != IDLE);
    assign redirect_pending_o = (state_q == PEND);
    assign ras_empty_o        = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen; RAS steps expect the PC_RAS_EN build when that macro is defined
module tb_pc_gen;
    import pc_pkg::*;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct {
        pc_t  pc;
        logic v;
        logic p;
        logic e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i, start_i, stall_i, hold_i, trap_i, redirect_i, call_i, ret_i;
    pc_t  trap_vec_i, redirect_pc_i, pc_o;
    logic pc_valid_o, redirect_pending_o, ras_empty_o;

    exp_t q[$];
    int   vectors = 0;
    int   fails   = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .stall_i           (stall_i),
        .hold_i            (hold_i),
        .trap_i            (trap_i),
        .trap_vec_i        (trap_vec_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .call_i            (call_i),
        .ret_i             (ret_i),
        .pc_o              (pc_o),
        .pc_valid_o        (pc_valid_o),
        .redirect_pending_o(redirect_pending_o),
        .ras_empty_o       (ras_empty_o)
    );

    task automatic step(input string tag, input pc_t pc, input logic v, input logic p, input logic e);
        exp_t x;
        q.push_back('{pc, v, p, e});
        @(posedge clk);
        #1;
        x = q.pop_front();
        vectors += 4;
        assert (pc_o === x.pc) else begin
            fails++;
            $error("FAIL %s pc_o got %h exp %h", tag, pc_o, x.pc);
        end
        assert (pc_valid_o === x.v) else begin
            fails++;
            $error("FAIL %s pc_valid_o got %b exp %b", tag, pc_valid_o, x.v);
        end
        assert (redirect_pending_o === x.p) else begin
            fails++;
            $error("FAIL %s redirect_pending_o got %b exp %b", tag, redirect_pending_o, x.p);
        end
        assert (ras_empty_o === x.e) else begin
            fails++;
            $error("FAIL %s ras_empty_o got %b exp %b", tag, ras_empty_o, x.e);
        end
    endtask

    initial begin
        rst_i = 1; start_i = 0; stall_i = 0; hold_i = 0; trap_i = 0; redirect_i = 0;
        call_i = 0; ret_i = 0; trap_vec_i = '0; redirect_pc_i = '0;
        @(negedge clk);
        step("reset", 32'h0, 0, 0, 1);
        rst_i = 0;
        for (int i = 0; i < 3; i++) step("idle", 32'h0, 0, 0, 1);
        start_i = 1;
        step("start", 32'h0, 1, 0, 1);
        step("seq4", 32'h4, 1, 0, 1);
        step("seq8", 32'h8, 1, 0, 1);
        step("seqC", 32'hC, 1, 0, 1);
        step("seq10", 32'h10, 1, 0, 1);
        stall_i = 1;
        step("stall1", 32'h10, 1, 0, 1);
        step("stall2", 32'h10, 1, 0, 1);
        stall_i = 0;
        step("unstall", 32'h14, 1, 0, 1);
        hold_i = 1; redirect_i = 1; redirect_pc_i = 32'h200;
        step("hold_redir", 32'h14, 1, 1, 1);
        redirect_i = 0;
        step("hold_pend", 32'h14, 1, 1, 1);
        hold_i = 0;
        step("pend_apply", 32'h200, 1, 0, 1);
        step("after_pend", 32'h204, 1, 0, 1);
        trap_i = 1; trap_vec_i = 32'h80; redirect_i = 1; redirect_pc_i = 32'h300;
        step("trap_wins", 32'h80, 1, 0, 1);
        trap_i = 0; redirect_i = 0;
        step("after_trap", 32'h84, 1, 0, 1);
        stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h300;
        step("pend_enter", 32'h84, 1, 1, 1);
        trap_i = 1; trap_vec_i = 32'h81; redirect_i = 0;
        step("pend_trap", 32'h80, 1, 0, 1);
        trap_i = 0; stall_i = 0;
        step("pend_dropped", 32'h84, 1, 0, 1);
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
        step("redir_top", 32'hFFFF_FFFC, 1, 0, 1);
        redirect_i = 0;
        step("wrap", 32'h0, 1, 0, 1);
        redirect_i = 1; redirect_pc_i = 32'h103;
        step("align", 32'h100, 1, 0, 1);
        hold_i = 1; redirect_pc_i = 32'h207;
        step("pend_a", 32'h100, 1, 1, 1);
        redirect_pc_i = 32'h30B;
        step("pend_overwrite", 32'h100, 1, 1, 1);
        hold_i = 0; redirect_i = 0;
        step("pend_new_tgt", 32'h308, 1, 0, 1);
        stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h400;
        step("pend_b", 32'h308, 1, 1, 1);
        start_i = 0; redirect_i = 0;
        step("stop_in_pend", 32'h0, 0, 0, 1);
        stall_i = 0; start_i = 1;
        step("restart", 32'h0, 1, 0, 1);
        step("restart_seq", 32'h4, 1, 0, 1);
        stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h500;
        step("pend_c", 32'h4, 1, 1, 1);
        rst_i = 1; redirect_i = 0;
        step("reset_in_pend", 32'h0, 0, 0, 1);
        rst_i = 0; stall_i = 0;
        step("post_reset_start", 32'h0, 1, 0, 1);
        redirect_i = 1; redirect_pc_i = 32'h40;
        step("to40", 32'h40, 1, 0, 1);
        call_i = 1; redirect_pc_i = 32'h80;
        step("call1", 32'h80, 1, 0, !RAS);
        redirect_pc_i = 32'h200;
        step("call2", 32'h200, 1, 0, !RAS);
        call_i = 0; redirect_i = 0; ret_i = 1;
        step("ret1", RAS ? 32'h84 : 32'h204, 1, 0, !RAS);
        step("ret2", RAS ? 32'h44 : 32'h208, 1, 0, 1);
        step("ret_empty", RAS ? 32'h48 : 32'h20C, 1, 0, 1);
        ret_i = 0;
        step("final_seq", RAS ? 32'h4C : 32'h210, 1, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined core. It replaces the fixed 32-bit, stall-by-rewind PC register with a registered next-PC selector that holds cleanly on stall, prioritises trap and redirect sources, and buffers a redirect that arrives during a stall. It can optionally include a small return-address stack that predicts subroutine returns. It sits between the hazard/branch logic and the instruction memory address port.

## Interface
- XLEN, 32, PC width in bits
- RESET_VEC, 0, PC value after reset and while not started
- INSTR_BYTES, 4, sequential increment; power of two
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2); used only with PC_RAS_EN

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  run enable; low forces idle
- stall_i  in  1  load-use hazard stall
- hold_i  in  1  memory/cache hold; same effect as stall_i
- trap_i  in  1  exception/trap request
- trap_vec_i  in  XLEN  trap target
- redirect_i  in  1  resolved branch/jump redirect
- redirect_pc_i  in  XLEN  redirect target
- call_i  in  1  the current redirect is a call (push link)
- ret_i  in  1  the fetched instruction is a return (pop prediction)
- pc_o  out  XLEN  fetch address (registered)
- pc_valid_o  out  1  pc_o is a valid fetch address
- redirect_pending_o  out  1  a buffered redirect is waiting for the stall to clear
- ras_empty_o  out  1  return-address stack is empty

## Operation
- FSM states: IDLE, RUN, PEND.
- On reset: pc_o=RESET_VEC, pc_valid_o=0, redirect_pending_o=0, ras_empty_o=1, state IDLE, RAS pointer 0.
- In IDLE: pc_o stays RESET_VEC. If start_i=1, go to RUN with pc_valid_o=1 and pc_o still RESET_VEC. The first fetch is RESET_VEC.
- In any state, start_i=0 forces IDLE on the next edge, with pc_o=RESET_VEC, pc_valid_o=0, and the pending redirect cleared.
- stall = stall_i | hold_i.
- RUN priority (highest first):
  - trap_i: pc_o←trap_vec_i.
  - redirect_i with no stall: pc_o←redirect_pc_i.
  - redirect_i with stall: capture redirect_pc_i in the pending register, go to PEND, pc_o unchanged.
  - ret_i (RAS only, not empty, no stall): pc_o←top of stack, then pop.
  - stall: pc_o unchanged.
  - Otherwise: pc_o←pc_o+INSTR_BYTES.
- PEND:
  - trap_i: pc_o←trap_vec_i, drop the pending redirect, go to RUN.
  - A new redirect_i overwrites the pending target, even while stalled.
  - When stall clears: pc_o←pending target, go to RUN. ret_i and sequential increment are ignored in PEND.
- Arithmetic and alignment:
  - Increment wraps modulo 2^XLEN. For example, 0xFFFFFFFC+4→0x00000000.
  - Targets are force-aligned by zeroing the low log2(INSTR_BYTES) bits of trap_vec_i, redirect_pc_i and the pending target.
- redirect_pending_o=1 exactly while the state is PEND.

## Timing
- Every output is registered. There is one cycle from any input to its effect on pc_o.
- There is no combinational path from any input to any output.
- Trap and redirect in the same cycle: trap wins and the redirect is discarded.
- Reset mid-stall or in PEND: reset wins and the pending redirect is lost.
- A stall sampled high holds pc_o for exactly that cycle. There is no rewind and no −INSTR_BYTES correction.

## Configuration
- PC_RAS_EN defined: a RAS_DEPTH-entry circular return-address stack is built.
  - Push: call_i & redirect_i & the redirect is applied (not buffered). The pushed value is pc_o+INSTR_BYTES.
  - Overflow overwrites the oldest entry.
  - ret_i on an empty stack is ignored and the increment is sequential.
  - Trap does not modify the stack.
- PC_RAS_EN undefined: call_i and ret_i are ignored, ras_empty_o is tied to 1, and no stack storage exists.

## Structure
- Shared package `pc_pkg` holds:
  - the FSM state enum (IDLE, RUN, PEND)
  - the pc_t typedef, parametrised via XLEN
  - the default RESET_VEC constant
- One natural sub-module, `pc_ras`: the circular stack with push, pop, top and empty.
  - It is instantiated only under PC_RAS_EN.

## Test plan
- Reset, then hold start_i=0 for 3 cycles, then start_i=1 → pc_o=0x0 with valid rising. pc_o then steps 0x4, 0x8, 0xC.
- At pc_o=0x10, stall_i=1 for 2 cycles → pc_o holds 0x10 for both cycles, then 0x14.
- hold_i=1 with redirect_i=1 and redirect_pc_i=0x200 → pc_o unchanged and redirect_pending_o=1. Release hold_i → pc_o=0x200 next cycle and pending clears.
- trap_i and redirect_i together, with trap_vec_i=0x80 and redirect_pc_i=0x300 → pc_o=0x80. Repeat while in PEND → the pending redirect is dropped.
- Set pc_o=0xFFFFFFFC, run one cycle → pc_o=0x0. Redirect to 0x103 → pc_o=0x100.
- PC_RAS_EN, RAS_DEPTH=4:
  - Call redirects from pc_o=0x40 and then 0x80 → stack holds 0x44 and 0x84.
  - ret_i → pc_o=0x84. A second ret_i → pc_o=0x44. A third ret_i → sequential increment, with ras_empty_o=1.
